alu_sequencer: RTL

Issue stage that sits directly upstream of the ALU. It accepts instructions over a valid/ready handshake and reads two operands from an internal 8×8-bit register file. It drives the ALU's control word and operand inputs, waits the ALU's fixed latency, captures the ALU result and writes it back to the destination register. It turns the ALU from a free-running datapath into a sequenced execute unit with architectural state.

---
 rtl/alu_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issue stage in front of a fixed-latency ALU. Accepts one instruction at a
//   time over valid/ready. Operands come from an internal 8x8 register file.
//   The ALU inputs are driven and held, the result is captured after ALU_LAT
//   edges, and it is written back to the destination register.
//
//   Optional feature macro: ALU_SEQ_ZERO_REG_EN
//     When defined, R0 reads as zero. Writes to address 0 are dropped, both
//     writeback and external writes.
//
// Parameters
//   ALU_LAT      ALU input-to-output latency in clock edges (1..7)
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   instr_valid  instruction offered
//   instr_ready  sequencer can accept (IDLE and out of reset)
//   instr[16:0]  {word[7:0], rd[2:0], rs1[2:0], rs2[2:0]}
//   ext_we/ext_addr/ext_data  external register-file write (any state)
//   alu_word/alu_in1/alu_in2  control word and operands driven to the ALU
//   alu_out      ALU result
//   result       last captured ALU result
//   result_valid one-cycle pulse after the capture edge
//   busy         state != IDLE
module alu_sequencer #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [16:0] instr,
    input  logic        ext_we,
    input  logic [2:0]  ext_addr,
    input  logic [7:0]  ext_data,
    output logic [7:0]  alu_word,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    input  logic [7:0]  alu_out,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    localparam logic [2:0] LAT = 3'(ALU_LAT);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic [2:0]  rd_q;
    logic [7:0]  rf [8];
    logic [7:0]  rs1_val, rs2_val;
    logic        accept, wb, wb_en, ext_en;

    assign accept = (state == IDLE) && instr_valid;
    assign wb     = (state == CAPTURE);

    // ready depends on rst_n directly so it reads 0 while reset is held
    assign instr_ready = rst_n && (state == IDLE);
    assign busy        = (state != IDLE);

`ifdef ALU_SEQ_ZERO_REG_EN
    assign rs1_val = (instr[5:3] == 3'd0) ? 8'h00 : rf[instr[5:3]];
    assign rs2_val = (instr[2:0] == 3'd0) ? 8'h00 : rf[instr[2:0]];
    assign wb_en   = wb && (rd_q != 3'd0);
    assign ext_en  = ext_we && (ext_addr != 3'd0) && !(wb && (ext_addr == rd_q));
`else
    assign rs1_val = rf[instr[5:3]];
    assign rs2_val = rf[instr[2:0]];
    assign wb_en   = wb;
    // writeback wins over an external write to the same register
    assign ext_en  = ext_we && !(wb && (ext_addr == rd_q));
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (instr_valid) state_nx = WAIT;
            // cnt == 1 means this edge takes it to zero
            WAIT:    if (cnt == 3'd1) state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_q         <= '0;
            alu_word     <= '0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            result_valid <= wb;
            if (accept) begin
                rd_q     <= instr[8:6];
                alu_word <= instr[16:9];
                alu_in1  <= rs1_val;
                alu_in2  <= rs2_val;
                cnt      <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
            if (wb) result <= alu_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            if (ext_en) rf[ext_addr] <= ext_data;
            if (wb_en)  rf[rd_q]     <= alu_out;
        end
    end

endmodule
